// File: rtl/cmp_pkg.sv
// Shared types and constants for the iterative magnitude comparator.
// Result codes use bit order {eq, lt, gt}.
package cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_EQ   = 3'b100;
  localparam logic [2:0] RES_LT   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b001;

  // Ceiling log2, used to size the digit index counter.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 32'sd0;
    v      = value - 32'sd1;
    while (v > 32'sd0) begin
      result = result + 32'sd1;
      v      = v >>> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/digit_compare.sv
// Combinational single-digit unsigned comparator.
// Equality from per-bit XNOR; greater-than from an MSB-first cascade in
// which a bit only decides the result while all higher bits are equal.
module digit_compare #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             eq,
  output logic             gt
);

  logic [DIGIT-1:0] same_s;
  logic             gt_s;
  logic             prefix_eq_s;

  // Per-bit equality and cascaded greater-than chain, MSB first.
  always_comb begin
    same_s      = x ~^ y;
    gt_s        = 1'b0;
    prefix_eq_s = 1'b1;
    for (int i = DIGIT - 1; i >= 0; i--) begin
      gt_s        = gt_s | (prefix_eq_s & x[i] & ~y[i]);
      prefix_eq_s = prefix_eq_s & same_s[i];
    end
  end

  assign eq = &same_s;
  assign gt = gt_s;

endmodule

// File: rtl/iterative_magnitude_comparator.sv
// Multi-cycle N-bit magnitude comparator: scans captured operands MSB-first,
// one DIGIT-bit digit per clock, and stops at the first differing digit.
// Optional feature macro: CMP_SIGNED_EN adds a signed_mode input that selects
// two's-complement ordering by inverting the operand sign bits at capture.
module iterative_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             a_eq_b,
  output logic             a_lt_b,
  output logic             a_gt_b
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IDXW = (clog2(NDIG) > 32'sd0) ? clog2(NDIG) : 32'sd1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NDIG - 1);
  localparam logic [IDXW-1:0] IDX_ONE = IDXW'(1);
  localparam logic [IDXW-1:0] IDX_ZERO = IDXW'(0);

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IDXW-1:0]  idx_r;
  logic [2:0]       flags_r;
  logic             busy_r;
  logic             done_r;

  logic [WIDTH-1:0] cap_a_s;
  logic [WIDTH-1:0] cap_b_s;
  logic [DIGIT-1:0] dig_a_s;
  logic [DIGIT-1:0] dig_b_s;
  logic             dig_eq_s;
  logic             dig_gt_s;

  // Operand values to capture; signed ordering flips both sign bits so an
  // unsigned scan yields the two's-complement result.
  always_comb begin
    cap_a_s = a;
    cap_b_s = b;
`ifdef CMP_SIGNED_EN
    if (signed_mode) begin
      cap_a_s[WIDTH-1] = ~a[WIDTH-1];
      cap_b_s[WIDTH-1] = ~b[WIDTH-1];
    end else begin
      cap_a_s = a;
      cap_b_s = b;
    end
`endif
  end

  // Select the digit currently under inspection.
  always_comb begin
    dig_a_s = a_r[int'(idx_r) * DIGIT +: DIGIT];
    dig_b_s = b_r[int'(idx_r) * DIGIT +: DIGIT];
  end

  digit_compare #(
    .DIGIT(DIGIT)
  ) u_digit_compare (
    .x (dig_a_s),
    .y (dig_b_s),
    .eq(dig_eq_s),
    .gt(dig_gt_s)
  );

  // Control FSM with registered busy/done/result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      idx_r   <= IDX_ZERO;
      flags_r <= RES_NONE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_r     <= cap_a_s;
            b_r     <= cap_b_s;
            idx_r   <= IDX_TOP;
            flags_r <= RES_NONE;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (abort) begin
            flags_r <= RES_NONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            state_r <= IDLE;
          end else if (!dig_eq_s) begin
            flags_r <= dig_gt_s ? RES_GT : RES_LT;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= IDLE;
          end else if (idx_r == IDX_ZERO) begin
            flags_r <= RES_EQ;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= IDLE;
          end else begin
            idx_r   <= idx_r - IDX_ONE;
            done_r  <= 1'b0;
            state_r <= RUN;
          end
        end
        default: begin
          flags_r <= RES_NONE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign a_eq_b = flags_r[2];
  assign a_lt_b = flags_r[1];
  assign a_gt_b = flags_r[0];

endmodule

// File: tb/tb_iterative_magnitude_comparator.sv
// Self-checking bench for iterative_magnitude_comparator (WIDTH=16, DIGIT=4).
// Define CMP_SIGNED_EN for both bench and RTL to exercise signed ordering.
module tb_iterative_magnitude_comparator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] a;
  logic [15:0] b;
`ifdef CMP_SIGNED_EN
  logic        signed_mode;
`endif
  logic        busy;
  logic        done;
  logic        a_eq_b;
  logic        a_lt_b;
  logic        a_gt_b;

  int checks = 0;
  int fails  = 0;

  iterative_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .a     (a),
    .b     (b),
`ifdef CMP_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .busy  (busy),
    .done  (done),
    .a_eq_b(a_eq_b),
    .a_lt_b(a_lt_b),
    .a_gt_b(a_gt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [2:0]  ef;
    int          el;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: ordering of the operands as numbers.
  function automatic logic [2:0] model_flags(input logic [15:0] x, input logic [15:0] y, input logic sm);
    int sx, sy;
    if (sm) begin
      sx = int'($signed(x));
      sy = int'($signed(y));
    end else begin
      sx = int'(x);
      sy = int'(y);
    end
    if (sx == sy) return 3'b100;
    else if (sx < sy) return 3'b010;
    else return 3'b001;
  endfunction

  // Reference: cycles until done = 4 minus the digit holding the highest differing bit.
  function automatic int model_lat(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] d;
    int msb;
    d = x ^ y;
    if (d == 16'h0000) return 4;
    msb = 15;
    while (!d[msb]) msb--;
    return 4 - msb / 4;
  endfunction

  // Wait for done; latency counts from the accepting edge.
  task automatic wait_done(input string nm, input int already, input logic [2:0] ef, input int el);
    int  lat;
    bit  seen;
    bit  busy_ok;
    lat = 0; seen = 1'b0; busy_ok = 1'b1;
    for (int i = already + 1; i <= 20 && !seen; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
    end
    chk({nm, "_done_seen"}, 32'(seen), 32'd1);
    chk({nm, "_latency"}, 32'(lat), 32'(el));
    chk({nm, "_flags"}, {29'd0, a_eq_b, a_lt_b, a_gt_b}, {29'd0, ef});
    chk({nm, "_busy"}, {30'd0, busy, busy_ok}, {30'd0, 1'b0, 1'b1});
  endtask

  task automatic run_cmp(input string nm, input logic [15:0] ta, input logic [15:0] tb2,
                         input logic sm, input logic [2:0] ef, input int el);
    a = ta;
    b = tb2;
`ifdef CMP_SIGNED_EN
    signed_mode = sm;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({nm, "_accept"}, {27'd0, busy, done, a_eq_b, a_lt_b, a_gt_b}, {27'd0, 5'b10000});
    a = 16'($urandom);
    b = 16'($urandom);
`ifdef CMP_SIGNED_EN
    signed_mode = ~sm;
`endif
    wait_done(nm, 0, ef, el);
  endtask

  vec_t vecs [7];

  initial begin
    logic [15:0] ra, rb;
    logic        rsm;
    vecs[0] = '{16'h1234, 16'h1234, 3'b100, 4};
    vecs[1] = '{16'h9000, 16'h1000, 3'b001, 1};
    vecs[2] = '{16'h12A4, 16'h12B4, 3'b010, 3};
    vecs[3] = '{16'h0000, 16'h0001, 3'b010, 4};
    vecs[4] = '{16'hFFFF, 16'h0000, 3'b001, 1};
    vecs[5] = '{16'h00F0, 16'h00E0, 3'b001, 3};
    vecs[6] = '{16'h1200, 16'h1300, 3'b010, 2};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = 16'h0000; b = 16'h0000;
`ifdef CMP_SIGNED_EN
    signed_mode = 1'b0;
`endif
    #23;
    chk("reset_outputs", {27'd0, busy, done, a_eq_b, a_lt_b, a_gt_b}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("after_reset_idle", {27'd0, busy, done, a_eq_b, a_lt_b, a_gt_b}, 32'd0);

    // Directed table.
    foreach (vecs[i]) begin
      run_cmp($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, 1'b0, vecs[i].ef, vecs[i].el);
      tick();
      chk($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
      chk($sformatf("vec%0d_hold", i), {29'd0, a_eq_b, a_lt_b, a_gt_b}, {29'd0, vecs[i].ef});
    end

    // Flags hold over idle cycles; abort in IDLE is a no-op.
    run_cmp("hold", 16'h1234, 16'h1234, 1'b0, 3'b100, 4);
    abort = 1'b1;
    tick(); tick();
    abort = 1'b0;
    tick();
    chk("hold_idle_abort", {27'd0, busy, done, a_eq_b, a_lt_b, a_gt_b}, {27'd0, 5'b00100});

    // Start re-pulsed while busy is ignored.
    a = 16'h1234; b = 16'h1234; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 16'h0000; b = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy_start", 2, 3'b100, 4);

    // Start coincident with done: accepted, flags clear on that edge.
    run_cmp("coinc_first", 16'h9000, 16'h1000, 1'b0, 3'b001, 1);
    run_cmp("coinc_second", 16'h0000, 16'h0001, 1'b0, 3'b010, 4);

    // Abort on cycle 2.
    a = 16'h0000; b = 16'h0001; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_state", {27'd0, busy, done, a_eq_b, a_lt_b, a_gt_b}, 32'd0);
    begin
      bit any_done;
      any_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (done) any_done = 1'b1;
      end
      chk("abort_no_done", {31'd0, any_done}, 32'd0);
    end
    run_cmp("after_abort", 16'h0000, 16'h0001, 1'b0, 3'b010, 4);

    // Asynchronous reset mid-operation.
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {27'd0, busy, done, a_eq_b, a_lt_b, a_gt_b}, 32'd0);
    tick();
    #2 rst_n = 1'b1;
    begin
      bit any_done;
      any_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (done) any_done = 1'b1;
      end
      chk("reset_no_done", {31'd0, any_done}, 32'd0);
    end
    run_cmp("after_reset", 16'h00A5, 16'h00A5, 1'b0, 3'b100, 4);

`ifdef CMP_SIGNED_EN
    run_cmp("signed_on", 16'h8000, 16'h0001, 1'b1, 3'b010, 1);
    run_cmp("signed_off", 16'h8000, 16'h0001, 1'b0, 3'b001, 1);
`endif

    // Randomized against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      if (i % 3 == 0) rb = ra;
      else if (i % 3 == 1) rb = ra ^ (16'h0001 << $urandom_range(15, 0));
      else rb = 16'($urandom);
`ifdef CMP_SIGNED_EN
      rsm = 1'($urandom);
`else
      rsm = 1'b0;
`endif
      run_cmp($sformatf("rand%0d", i), ra, rb, rsm, model_flags(ra, rb, rsm), model_lat(ra, rb));
      if (i % 4 == 0) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/iterative_magnitude_comparator.md
Name: iterative_magnitude_comparator

Overview:
Multi-cycle, parametrised N-bit magnitude comparator. Scans operands MSB-first, DIGIT bits per clock, and exits early on the first differing digit. Registered EQ/LT/GT flags are held until the next operation; a start/busy/done handshake lets a sequencer share one compact comparator across wide operands.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits compared per clock cycle; NDIG = WIDTH/DIGIT.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a comparison; accepted only when busy=0.
abort  input  1  synchronous cancel of an operation in progress.
a  input  WIDTH  operand A; sampled on the accepting edge only.
b  input  WIDTH  operand B; sampled on the accepting edge only.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse; result flags are valid from this cycle on.
a_eq_b  output  1  registered A==B.
a_lt_b  output  1  registered A<B.
a_gt_b  output  1  registered A>B.

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous and active-low.
- Reset values: busy=0, done=0, a_eq_b=0, a_lt_b=0, a_gt_b=0. After reset all three flags are 0, meaning "no result". State goes to IDLE.
- FSM states: IDLE and RUN.
- IDLE:
  - start=1 captures a and b into internal registers, clears all three flags, sets idx=NDIG-1 and moves to RUN.
  - busy rises on the same edge.
- RUN: each cycle compares digit idx of the captured A and B.
  - Digits differ: set a_lt_b or a_gt_b, pulse done, go to IDLE (early exit).
  - Digits equal and idx==0: set a_eq_b, pulse done, go to IDLE.
  - Otherwise: decrement idx and stay in RUN.
- Latency, from the accepting edge to the edge that raises done: k cycles, where k is the position of the first differing digit counted from the MSB (1..NDIG). For equal operands, k=NDIG.
- Result flags: exactly one flag is 1 after any done. Flags hold until the next accepted start, which clears them.
- start while busy=1: ignored, with no side effects.
- start in the same cycle as a done pulse: accepted, since the FSM is already in IDLE.
- abort=1 in RUN: go to IDLE with flags=000 and no done pulse. abort has priority over completion in the same cycle. abort in IDLE has no effect.
- rst_n low mid-operation: immediate return to reset values. No done is issued.
- Operand changes after acceptance have no effect on the result.
- Unsigned comparison by default.

Optional Feature:
CMP_SIGNED_EN
- Defined:
  - Adds input port signed_mode (1 bit), sampled with the operands at start.
  - When the captured signed_mode=1, bit WIDTH-1 of both captured operands is inverted before the scan. This gives two's-complement ordering; latency is unchanged.
- Undefined: the port is absent and all comparisons are unsigned.

Decomposition:
- Package cmp_pkg:
  - State enum {IDLE, RUN}.
  - Result-code constants RES_NONE=3'b000, RES_EQ=3'b100, RES_LT=3'b010, RES_GT=3'b001 (bit order eq,lt,gt).
  - Function clog2 for the idx counter width.
- Sub-module digit_compare:
  - Combinational; parameter DIGIT; inputs x[DIGIT] and y[DIGIT]; outputs eq, gt.
  - Uses per-bit XNOR equality with a cascaded greater-than chain. lt is derived as ~(eq|gt).
  - Instantiated once by the top level, with its inputs muxed by idx.

Test Plan (WIDTH=16, DIGIT=4):
- a=16'h1234, b=16'h1234, start pulse -> busy for 4 cycles; done on cycle 4 after acceptance; flags eq,lt,gt=100, held until next start.
- a=16'h9000, b=16'h1000 -> done 1 cycle after acceptance, flags=001. Then a=16'h12A4, b=16'h12B4 -> done after 3 cycles, flags=010.
- Start accepted, then start re-pulsed on cycle 1 with new operands -> ignored; result reflects the first operands. A start coincident with done -> second operation begins, flags clear on the next edge.
- a=16'h0000, b=16'h0001, abort on cycle 2 -> busy drops, flags=000, no done. Next start completes normally (flags=010 after 4 cycles).
- rst_n low on cycle 2 of a compare of 16'hFFFF vs 16'hFFFF -> all outputs 0 asynchronously, no done. After release, a new start works.
- CMP_SIGNED_EN defined, a=16'h8000, b=16'h0001: signed_mode=1 -> flags=010 after 1 cycle; signed_mode=0 -> flags=001 after 1 cycle.
